// File: rtl/demultiplexer_stream_4.sv
// rtl/demultiplexer_stream_4.sv - registered 1-to-4 valid/ready stream demultiplexer
//
// Purpose:
//   Routes one valid/ready input stream to one of four output streams. The
//   destination is chosen per beat by sel. Each output channel owns a
//   one-entry holding register, so a stalled consumer blocks only the beats
//   that are addressed to it. Beats to one channel keep their acceptance
//   order. Beats to different channels are not ordered against each other.
//
// Optional feature (macro DEMULTIPLEXER_STREAM_4_COUNT_EN):
//   Adds four saturating 8-bit transfer counters cnt_0..cnt_3 and a
//   synchronous clear_counts input. Without the macro, those ports and the
//   counter logic do not exist.
//
// Ports:
//   clock                    rising-edge clock
//   reset                    synchronous, active-high reset
//   enable                   low blocks new input beats; held beats still drain
//   in_valid / in_ready      input handshake (in_ready is combinational)
//   in_data [nrOfBits]       input payload
//   sel [2]                  destination channel of the current input beat
//   out_valid_k              channel k holding register full
//   out_ready_k              consumer k accepts this cycle
//   out_data_k [nrOfBits]    channel k payload (registered, holds after drain)
//   clear_counts             (optional) zero all transfer counters
//   cnt_k [8]                (optional) saturating output-transfer count, channel k

module demultiplexer_stream_4 #(
    parameter int nrOfBits = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [nrOfBits-1:0] in_data,
    input  logic [1:0]          sel,
    output logic                out_valid_0,
    output logic                out_valid_1,
    output logic                out_valid_2,
    output logic                out_valid_3,
    input  logic                out_ready_0,
    input  logic                out_ready_1,
    input  logic                out_ready_2,
    input  logic                out_ready_3,
`ifdef DEMULTIPLEXER_STREAM_4_COUNT_EN
    input  logic                clear_counts,
    output logic [7:0]          cnt_0,
    output logic [7:0]          cnt_1,
    output logic [7:0]          cnt_2,
    output logic [7:0]          cnt_3,
`endif
    output logic [nrOfBits-1:0] out_data_0,
    output logic [nrOfBits-1:0] out_data_1,
    output logic [nrOfBits-1:0] out_data_2,
    output logic [nrOfBits-1:0] out_data_3
);

    localparam int NrChannels = 4;

    // Per-channel holding registers. validReg[k] is the only channel state
    // (EMPTY = 0, FULL = 1).
    logic [NrChannels-1:0] validReg;
    logic [nrOfBits-1:0]   dataReg [NrChannels];

    logic [NrChannels-1:0] readyVec;
    logic [NrChannels-1:0] loadVec;
    logic [NrChannels-1:0] drainVec;
    logic                  selFree;
    logic                  accept;

    assign readyVec = {out_ready_3, out_ready_2, out_ready_1, out_ready_0};

    // Only the selected channel gates acceptance. A FULL channel can still
    // take a beat when its consumer drains that same cycle. in_ready has no
    // path from in_valid, so an upstream source may wait for it before
    // asserting valid.
    always_comb begin
        selFree      = ~validReg[sel] | readyVec[sel];
        in_ready     = enable & ~reset & selFree;
        accept       = in_valid & in_ready;
        loadVec      = '0;
        loadVec[sel] = accept;
        drainVec     = validReg & readyVec;
    end

    // A load on channel k wins over a same-cycle drain of channel k. The new
    // beat replaces the old one and the channel stays FULL. This gives
    // 1 beat/cycle per channel. A channel that is not loaded drains on its own.
    always_ff @(posedge clock) begin
        if (reset) begin
            validReg <= '0;
            for (int k = 0; k < NrChannels; k++) begin
                dataReg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NrChannels; k++) begin
                if (loadVec[k]) begin
                    validReg[k] <= 1'b1;
                    dataReg[k]  <= in_data;
                end else if (drainVec[k]) begin
                    validReg[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid_0 = validReg[0];
    assign out_valid_1 = validReg[1];
    assign out_valid_2 = validReg[2];
    assign out_valid_3 = validReg[3];

    // Data is not cleared on drain. The last payload stays visible.
    assign out_data_0  = dataReg[0];
    assign out_data_1  = dataReg[1];
    assign out_data_2  = dataReg[2];
    assign out_data_3  = dataReg[3];

`ifdef DEMULTIPLEXER_STREAM_4_COUNT_EN
    logic [7:0] countReg [NrChannels];

    // The counters count completed output handshakes. clear_counts beats a
    // same-cycle increment. A counter stops at 255 instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset || clear_counts) begin
            for (int k = 0; k < NrChannels; k++) begin
                countReg[k] <= 8'd0;
            end
        end else begin
            for (int k = 0; k < NrChannels; k++) begin
                if (drainVec[k] && (countReg[k] != 8'hFF)) begin
                    countReg[k] <= countReg[k] + 8'd1;
                end
            end
        end
    end

    assign cnt_0 = countReg[0];
    assign cnt_1 = countReg[1];
    assign cnt_2 = countReg[2];
    assign cnt_3 = countReg[3];
`endif

endmodule

// File: doc/demultiplexer_stream_4.md
Name: demultiplexer_stream_4

Overview:
- Registered 1-to-4 stream demultiplexer. It routes one valid/ready input stream to one of four output streams, chosen per beat by sel.
- It is the distribution-side counterpart of the 4-input bus multiplexers used across the logic library. It fans shared data paths back out to per-unit consumers.
- Each output channel has a one-entry holding register, so one slow consumer stalls only beats addressed to it.

Parameters:
- nrOfBits, 1, width of the data bus on the input and every output.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when low, no new input beats are accepted; buffered beats still drain.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle (combinational).
- in_data  input  nrOfBits  input payload.
- sel  input  2  destination channel for the current input beat (0..3).
- out_valid_0..out_valid_3  output  1 each  channel k holding register full.
- out_ready_0..out_ready_3  input  1 each  consumer k accepts this cycle.
- out_data_0..out_data_3  output  nrOfBits each  channel k payload (registered).

Behaviour:
- Reset (reset=1 at clock edge):
  - all out_valid_k go to 0 and all out_data_k go to 0.
  - Reset wins over any simultaneous transfer. A beat offered during the reset cycle is lost.
  - in_ready is 0 while reset is high.
- Per-channel state: EMPTY (out_valid_k=0) or FULL (out_valid_k=1). There is no other state.
- in_ready = enable & ~reset & (~out_valid[sel] | out_ready[sel]).
  - in_ready depends only on the selected channel.
  - It is independent of in_valid. It has no combinational path from in_valid.
- Input transfer: occurs when in_valid & in_ready.
  - At the next edge, out_data[sel] <= in_data and out_valid[sel] <= 1.
  - Latency is 1 cycle from acceptance to visibility on the output.
- Output transfer: occurs on channel k when out_valid_k & out_ready_k.
  - At the edge, out_valid_k <= 0 unless the same edge loads channel k.
- Simultaneous drain and load on the same channel: the new beat replaces the old one and out_valid_k stays 1. This gives full throughput of 1 beat/cycle per channel.
- Unselected channels:
  - They drain independently every cycle, regardless of enable, in_valid or sel.
  - They never load.
- Order: beats to the same channel are delivered in acceptance order. No ordering is guaranteed across channels.
- out_data_k holds its last value after drain. Its contents are don't-care while out_valid_k=0, but the holding behaviour is required.
- sel changing while in_valid=1 and in_ready=0:
  - allowed; the beat is re-targeted.
  - No state is affected until a transfer occurs.
- enable falling while channels are FULL: the channels keep their data and drain normally.
- Upstream contract: in_data and sel must be held stable while in_valid=1 and no transfer has occurred. This is required only for sources that need it; the block itself does not depend on it.

Optional Feature:
- Macro: DEMULTIPLEXER_STREAM_4_COUNT_EN.
- When defined, the block adds:
  - four 8-bit outputs cnt_0..cnt_3.
  - Each counter increments by 1 on every output transfer of its channel.
  - Each counter saturates at 255 and never wraps.
  - A clear_counts input (1 bit) zeroes all four counters synchronously.
  - clear_counts has priority over a same-cycle increment.
  - Reset zeroes all counters.
- When undefined: the cnt_k ports, the clear_counts port and the counter logic do not exist. The remaining behaviour is identical.

Test Plan:
- Reset, then a single beat:
  - Stimulus: after reset, in_valid=1, sel=2, in_data=0x5A (nrOfBits=8), all out_ready=0.
  - Response: in_ready=1; next cycle out_valid_2=1 and out_data_2=0x5A; other channels stay valid=0.
  - Then a second beat to sel=2 sees in_ready=0.
- Streaming:
  - Stimulus: sel=1, out_ready_1=1 held, 8 back-to-back beats 0x00..0x07.
  - Response: in_ready stays 1 every cycle; out_data_1 shows 0x00..0x07 on consecutive cycles with out_valid_1=1; no bubbles.
- Head-of-line isolation:
  - Stimulus: channel 0 FULL with out_ready_0=0; then beats to sel=0 (0x11) and sel=3 (0x33).
  - Response: the sel=0 beat stalls (in_ready=0). After sel switches to 3, the 0x33 beat is accepted and appears on channel 3 one cycle later. Channel 0 still holds its original data.
- Enable low:
  - Stimulus: channel 1 FULL, enable=0, in_valid=1 on every sel value, out_ready_1 pulsed high.
  - Response: in_ready=0 throughout; channel 1 drains (out_valid_1 drops); no loads occur.
- Reset mid-operation:
  - Stimulus: channels 0..3 FULL; assert reset for one cycle while in_valid=1 and sel=0.
  - Response: the next cycle has all out_valid_k=0 and all out_data_k=0; the offered beat is dropped.
- With DEMULTIPLEXER_STREAM_4_COUNT_EN:
  - Stimulus: 300 transfers on channel 0 and 3 on channel 2.
  - Response: cnt_0=255 (saturated) and cnt_2=3.
  - clear_counts=1 coincident with a channel 2 transfer gives cnt_2=0.
